// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared encodings for the program-counter sequencer
// Next-PC source select, FSM states and the interrupt vector helper.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_WREG = 2'd1,
    SEL_LIT  = 2'd2,
    SEL_RET  = 2'd3
  } pc_sel_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ISR = 1'b1
  } state_e;

  // Full-width result; callers truncate to the program address width.
  function automatic int unsigned vec_addr(input int unsigned base,
                                           input int unsigned stride,
                                           input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/status bundle between core and sequencer
// master drives the step controls, slave is the sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W      = 11,
  parameter int NUM_IRQ     = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic               advance;
  logic [1:0]         pc_sel;
  logic               skip;
  logic [ADDR_W-1:0]  wreg_addr;
  logic [ADDR_W-1:0]  literal;
  logic [NUM_IRQ-1:0] irq;
  logic               irq_en;
  logic               reti;
  logic [ADDR_W-1:0]  pc;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               in_isr;
  logic [LVL_W-1:0]   stack_level;
  logic               stack_ovf;
  logic               stack_unf;

  modport master (
    output advance, pc_sel, skip, wreg_addr, literal, irq, irq_en, reti,
    input  pc, irq_ack, in_isr, stack_level, stack_ovf, stack_unf
  );

  modport slave (
    input  advance, pc_sel, skip, wreg_addr, literal, irq, irq_en, reti,
    output pc, irq_ack, in_isr, stack_level, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// rtl/pc_sequencer_return_stack.sv - hardware return-address stack
// Push when full and pop when empty are ignored; the caller flags them.
module return_stack #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_i,
  input  logic                               pop_i,
  input  logic [ADDR_W-1:0]                  push_data_i,
  output logic [ADDR_W-1:0]                  top_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   level_o,
  output logic                               full_o,
  output logic                               empty_o
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  assign full_o  = (level_q == LVL_W'(STACK_DEPTH));
  assign empty_o = (level_q == '0);
  assign wr_ptr  = PTR_W'(level_q);
  assign rd_ptr  = PTR_W'(level_q - LVL_W'(1));
  assign top_o   = mem_q[rd_ptr];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (push_i && !full_o)      level_d = level_q + LVL_W'(1);
    else if (pop_i && !empty_o) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) level_q <= '0;
    else       level_q <= level_d;
  end

  // Entries carry no reset; only the level decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr] <= push_data_i;
  end
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with call/return stack and vectored IRQs
// All state moves only on an advance strobe; interrupt entry outranks pc_sel and reti.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          ADDR_W      = 11,
  parameter int          STACK_DEPTH = 4,
  parameter int          NUM_IRQ     = 4,
  parameter int unsigned VEC_BASE    = 'h004,
  parameter int unsigned VEC_STRIDE  = 2
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  pc_sequencer_if.slave  seq_io
);
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               push, pop;
  logic [ADDR_W-1:0]  push_data, top;
  logic               full, empty;
  logic [ADDR_W-1:0]  seq_tgt, vec;
  int unsigned        irq_idx;
  pc_sel_e            sel;

  assign sel     = pc_sel_e'(seq_io.pc_sel);
  assign seq_tgt = pc_q + (seq_io.skip ? ADDR_W'(2) : ADDR_W'(1));

  always_comb begin
    irq_idx = 0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (seq_io.irq[i]) irq_idx = unsigned'(i);
    end
  end

  assign vec = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, irq_idx));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ack_d     = '0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_q;
    if (seq_io.advance) begin
      if (state_q == ST_RUN && seq_io.irq_en && |seq_io.irq) begin
        // The interrupted instruction is discarded, so its own address is saved.
        push    = 1'b1;
        pc_d    = vec;
        ack_d   = NUM_IRQ'(1) << irq_idx;
        state_d = ST_ISR;
        if (full) ovf_d = 1'b1;
      end else if (seq_io.reti || sel == SEL_RET) begin
        if (empty) begin
          pc_d  = seq_tgt;
          unf_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = top;
        end
        if (seq_io.reti) state_d = ST_RUN;
      end else begin
        case (sel)
          SEL_WREG, SEL_LIT: begin
            push      = 1'b1;
            push_data = pc_q + ADDR_W'(1);
            pc_d      = (sel == SEL_WREG) ? seq_io.wreg_addr : seq_io.literal;
            if (full) ovf_d = 1'b1;
          end
          default: pc_d = seq_tgt;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      ack_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_i       (CLOCK_50),
    .rst_i       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .top_o       (top),
    .level_o     (seq_io.stack_level),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign seq_io.pc        = pc_q;
  assign seq_io.irq_ack   = ack_q;
  assign seq_io.in_isr    = (state_q == ST_ISR);
  assign seq_io.stack_ovf = ovf_q;
  assign seq_io.stack_unf = unf_q;
endmodule
